cache_fill_fsm: RTL

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_pkg.sv | 16 +
 rtl/fill_word_cnt.sv | 26 ++
 rtl/cache_fill_fsm.sv | 109 ++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared constants and the fill state type for the cache block-fill controller.
package cache_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORD_IDX_W      = 3;
  localparam int BLK_W           = ADDR_W - BLOCK_OFFSET_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fill_word_cnt.sv
// Word counter used for both read issue and data receive; wraps at the block size.
module fill_word_cnt
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller: issues one word read per cycle, writes returned words.
// Optional perf counter output fill_count is built when CACHE_FILL_PERF_CNT_EN is defined.
module cache_fill_fsm #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           fsm_busy,
  output logic                           memory_read_en,
  output logic [15:0]                    memory_address,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [cache_pkg::WORD_IDX_W-1:0] cache_word_idx,
  output logic [15:0]                    fill_data
`ifdef CACHE_FILL_PERF_CNT_EN
  ,
  output logic [15:0]                    fill_count
`endif
);

  import cache_pkg::*;

  if (WORDS_PER_BLOCK != (1 << WORD_IDX_W)) begin : g_bad_words_per_block
    $error("WORDS_PER_BLOCK must match the word index width");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end

  fill_state_e           state_q;
  logic [BLK_W-1:0]      blk_q;
  logic                  issue_active_q;
  logic [WORD_IDX_W-1:0] issue_cnt;
  logic [WORD_IDX_W-1:0] recv_cnt;
  logic                  issue_tc;
  logic                  recv_tc;
  logic                  start;
  logic                  recv_fire;
  logic                  last_word;
  logic                  unused_offset;

  // NOTE: rst_n gates the combinational stall so outputs read 0 while reset is held.
  assign start     = (state_q == IDLE) && miss_detected && rst_n;
  assign recv_fire = (state_q == FILL) && memory_data_valid;
  assign last_word = recv_fire && recv_tc;
  assign unused_offset = ^miss_address[BLOCK_OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      issue_active_q <= 1'b0;
    end else if (start) begin
      state_q        <= FILL;
      blk_q          <= miss_address[ADDR_W-1:BLOCK_OFFSET_W];
      issue_active_q <= 1'b1;
    end else if (state_q == FILL) begin
      if (last_word) begin
        state_q        <= IDLE;
        issue_active_q <= 1'b0;
      end else if (issue_active_q && issue_tc) begin
        issue_active_q <= 1'b0;
      end
    end
  end

  fill_word_cnt u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (issue_active_q),
    .clr   (start),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  fill_word_cnt u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (recv_fire),
    .clr   (start),
    .cnt   (recv_cnt),
    .tc    (recv_tc)
  );

  assign fsm_busy         = (state_q == FILL) || start;
  assign memory_read_en   = issue_active_q;
  assign memory_address   = issue_active_q ? {blk_q, issue_cnt, 1'b0} : '0;
  assign write_data_array = recv_fire;
  assign write_tag_array  = last_word;
  assign cache_word_idx   = recv_fire ? recv_cnt : '0;
  assign fill_data        = recv_fire ? memory_data : '0;

`ifdef CACHE_FILL_PERF_CNT_EN
  // Saturating count of completed fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (last_word && (fill_count != 16'hFFFF)) begin
      fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule
